// File: rtl/snn_pkg.sv
// Shared fixed-point constants, scan FSM state type and saturation helper
// for the spiking output layer.
package snn_pkg;
  localparam int V_W      = 25;
  localparam int N_NEURON = 18;
  localparam int Q_ONE    = 65536;
  localparam logic signed [V_W-1:0] THRESH_DEF = 25'sd1310720;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } tx_state_t;

  // Clamp a widened sum back into the membrane range.
  function automatic logic signed [V_W-1:0] sat_v(
    input logic signed [V_W+1:0] s,
    input logic signed [V_W-1:0] lo,
    input logic signed [V_W-1:0] hi
  );
    logic signed [V_W+1:0] lo_x, hi_x;
    lo_x = {{2{lo[V_W-1]}}, lo};
    hi_x = {{2{hi[V_W-1]}}, hi};
    if (s < lo_x)      sat_v = lo;
    else if (s > hi_x) sat_v = hi;
    else               sat_v = s[V_W-1:0];
  endfunction
endpackage

// File: rtl/lif_update.sv
// One leaky integrate-and-fire step for a single neuron; purely combinational,
// shared across the scan.
module lif_update
  import snn_pkg::*;
#(
  parameter logic signed [V_W-1:0] THRESH = THRESH_DEF,
  parameter logic signed [V_W-1:0] VMIN   = -25'sd1310720,
  parameter logic signed [V_W-1:0] VMAX   = 25'sd8388607,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRAC     = 2
) (
  input  logic signed [V_W-1:0] v,
  input  logic signed [V_W-1:0] cur,
  input  logic signed [V_W-1:0] inhbt,
  input  logic                  last_spike,
  input  logic [2:0]            ref_cnt,
  output logic signed [V_W-1:0] v_next,
  output logic [2:0]            ref_next,
  output logic                  spike
);
  logic signed [V_W-1:0] leak, sv;
  logic signed [V_W+1:0] vx, lx, cx, ix, s;

  always_comb begin
    leak = v >>> LEAK_SHIFT;
    vx   = {{2{v[V_W-1]}}, v};
    lx   = {{2{leak[V_W-1]}}, leak};
    cx   = {{2{cur[V_W-1]}}, cur};
    // neurons that fired last timestep skip inhibition
    ix   = last_spike ? '0 : {{2{inhbt[V_W-1]}}, inhbt};
    s    = vx - lx + cx - ix;
    sv   = sat_v(s, VMIN, VMAX);
    spike    = 1'b0;
    v_next   = '0;
    ref_next = '0;
    if (ref_cnt != 3'd0) begin
      ref_next = ref_cnt - 3'd1;
    end else if (sv >= THRESH) begin
      spike    = 1'b1;
      ref_next = 3'(REFRAC);
    end else begin
      v_next = sv;
    end
  end
endmodule

// File: rtl/lif_spike_tx.sv
// Serial spike transmitter: per timestep, updates each neuron's LIF state in
// turn and emits one registered (valid, spike, idx) beat per cycle.
module lif_spike_tx #(
  parameter int N_NEURON = 18,
  parameter int V_W      = 25,
  parameter logic signed [V_W-1:0] THRESH = 25'sd1310720,
  parameter logic signed [V_W-1:0] VMIN   = -25'sd1310720,
  parameter logic signed [V_W-1:0] VMAX   = 25'sd8388607,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRAC     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_start,
  input  logic [N_NEURON*V_W-1:0] i_current,
  input  logic [V_W-1:0]          i_inhbt,
  input  logic                    i_clr_state,
  output logic                    o_valid,
  output logic                    o_spike,
  output logic [4:0]              o_neuron_idx,
  output logic                    o_busy,
  output logic                    o_done
);
  snn_pkg::tx_state_t state, state_nx;

  logic signed [V_W-1:0] v_q [N_NEURON];
  logic [2:0]            ref_q [N_NEURON];
  logic [N_NEURON-1:0]   ls_q;
  logic [N_NEURON*V_W-1:0] cur_sh, cur_all;
  logic signed [V_W-1:0] inh_sh, inh_sel, cur_k, v_nx;
  logic [2:0]            ref_nx;
  logic                  spk_nx, in_load, upd_en;
  logic [4:0]            k;

  // Neuron k is updated on the edge that presents its beat, so beat 0 is
  // computed at the end of LOAD straight from the live inputs.
  assign in_load = (state == snn_pkg::ST_LOAD);
  assign upd_en  = in_load ||
                   (state == snn_pkg::ST_SCAN && o_neuron_idx != 5'(N_NEURON-1));
  assign k       = !upd_en ? 5'd0 : (in_load ? 5'd0 : o_neuron_idx + 5'd1);
  assign cur_all = in_load ? i_current : cur_sh;
  assign inh_sel = in_load ? i_inhbt : inh_sh;
  assign cur_k   = cur_all[k*V_W +: V_W];

  always_comb begin
    state_nx = state;
    case (state)
      snn_pkg::ST_IDLE: if (i_start) state_nx = snn_pkg::ST_LOAD;
      snn_pkg::ST_LOAD: state_nx = snn_pkg::ST_SCAN;
      snn_pkg::ST_SCAN: if (o_neuron_idx == 5'(N_NEURON-1)) state_nx = snn_pkg::ST_DONE;
      default:          state_nx = snn_pkg::ST_IDLE;
    endcase
  end

  lif_update #(
    .THRESH(THRESH), .VMIN(VMIN), .VMAX(VMAX),
    .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
  ) u_upd (
    .v(v_q[k]), .cur(cur_k), .inhbt(inh_sel), .last_spike(ls_q[k]),
    .ref_cnt(ref_q[k]), .v_next(v_nx), .ref_next(ref_nx), .spike(spk_nx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= snn_pkg::ST_IDLE;
      o_valid      <= 1'b0;
      o_spike      <= 1'b0;
      o_neuron_idx <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      cur_sh       <= '0;
      inh_sh       <= '0;
      ls_q         <= '0;
      for (int i = 0; i < N_NEURON; i++) begin
        v_q[i]   <= '0;
        ref_q[i] <= '0;
      end
    end else if (i_clr_state) begin
      state        <= snn_pkg::ST_IDLE;
      o_valid      <= 1'b0;
      o_spike      <= 1'b0;
      o_neuron_idx <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      ls_q         <= '0;
      for (int i = 0; i < N_NEURON; i++) begin
        v_q[i]   <= '0;
        ref_q[i] <= '0;
      end
    end else begin
      state   <= state_nx;
      o_busy  <= (state_nx == snn_pkg::ST_LOAD) || (state_nx == snn_pkg::ST_SCAN);
      o_done  <= (state_nx == snn_pkg::ST_DONE);
      o_valid <= upd_en;
      o_spike <= upd_en & spk_nx;
      if (in_load) begin
        cur_sh <= i_current;
        inh_sh <= i_inhbt;
      end
      if (upd_en) begin
        o_neuron_idx <= k;
        v_q[k]       <= v_nx;
        ref_q[k]     <= ref_nx;
        ls_q[k]      <= spk_nx;
      end
    end
  end
endmodule

// File: doc/lif_spike_tx.md
# lif_spike_tx

Serial spike transmitter for the 18-neuron output layer. Once per timestep it scans neurons 0..17 and emits one `(valid, spike, neuron_idx)` beat per cycle, which is the stream the post-synaptic buffer consumes. For each neuron it holds the leaky integrate-and-fire state: membrane potential, refractory counter and last-spike bit. It integrates the per-neuron input current minus the lateral inhibition fed back from the post-synaptic buffer.

## Interface
Parameters:
- `N_NEURON`, 18, neurons per scan; must be ≤ 32.
- `V_W`, 25, signed membrane/current width, Q8.16 format.
- `THRESH`, 25'd1310720, firing threshold (20.0).
- `VMIN`, -25'sd1310720, lower saturation bound (-20.0).
- `VMAX`, 25'sd8388607, upper saturation bound.
- `LEAK_SHIFT`, 4, leak is `v >>> LEAK_SHIFT` (arithmetic shift).
- `REFRAC`, 2, refractory length in timesteps; range 0..7.

Ports:
- `clk` input 1: clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `i_start` input 1: single-cycle pulse that starts one timestep scan.
- `i_current` input N_NEURON*V_W: signed currents; neuron k occupies `[k*V_W +: V_W]`.
- `i_inhbt` input V_W signed: lateral inhibition from the previous timestep.
- `i_clr_state` input 1: synchronous clear of all neuron state.
- `o_valid` output 1: beat valid.
- `o_spike` output 1: spike for the current beat.
- `o_neuron_idx` output 5: index of the current beat.
- `o_busy` output 1: high in LOAD and SCAN.
- `o_done` output 1: one-cycle pulse after the last beat.

## Operation
- FSM states: IDLE, LOAD, SCAN, DONE.
  - IDLE → LOAD on `i_start`.
  - LOAD → SCAN unconditionally.
  - SCAN → DONE after the beat with idx N_NEURON-1.
  - DONE → IDLE unconditionally.
- LOAD latches `i_current` and `i_inhbt` into shadow registers. Inputs may change freely after LOAD.
- `i_start` outside IDLE is ignored; it is not queued.
- SCAN processes neuron k = idx (0..N_NEURON-1), one per cycle:
  - Refractory case (`ref[k] != 0`): `ref[k]--`, `v[k] <= 0`, `o_spike = 0`.
  - Otherwise, in this order:
    1. `d = v - (v >>> LEAK_SHIFT)`.
    2. `s = d + cur[k] - (last_spike[k] ? 0 : inhbt)`, computed at V_W+2 bits.
    3. Saturate s to [VMIN, VMAX].
    4. If `s >= THRESH` (signed compare): `o_spike = 1`, `v[k] <= 0`, `ref[k] <= REFRAC`. Else `o_spike = 0`, `v[k] <= s`.
  - Every SCAN beat sets `last_spike[k] <= o_spike`.
- Neurons that spiked in the previous timestep are exempt from inhibition.
- `i_clr_state` clears all `v`, `ref` and `last_spike` to 0 and forces the FSM to IDLE. A scan in progress is aborted: no further beats are emitted and there is no `o_done`.
- `i_clr_state` and `i_start` in the same cycle: clear wins and the start is dropped.
- Reset values: FSM = IDLE; all state and shadow registers = 0; every output = 0.

## Timing
- `i_start` is sampled at edge 0. LOAD occupies cycle 1.
- `o_valid` is high on cycles 2..N_NEURON+1 (2..19 at the default), with `o_neuron_idx` running 0..17 consecutively with no gaps.
- `o_done` is high on cycle N_NEURON+2 (20). `o_busy` is high on cycles 1..19.
- Earliest next `i_start` is accepted on cycle 21, for a throughput of 21 cycles per timestep.
- All outputs are registered; `o_spike` and `o_neuron_idx` are valid in the same cycle as `o_valid`.
- `i_inhbt` is sampled only in LOAD. The post-synaptic buffer's inhibition output settles one cycle after beat 17, so it is ready for the next timestep.
- An asynchronous `reset_n` assertion mid-scan drops `o_valid` immediately. After release the block is in IDLE.

## Structure
- Shared package `snn_pkg` holds `V_W`, `N_NEURON`, `Q_ONE` = 65536, `THRESH_DEF`, the state enum `tx_state_t`, and a saturation function.
- One sub-module, `lif_update`, is purely combinational:
  - Inputs: `v`, `cur`, `inhbt`, `last_spike`, `ref`.
  - Outputs: `v_next`, `ref_next`, `spike`.
- The top level holds the FSM, index counter, shadow registers and state register arrays.

## Test plan
- **Integration:** `cur[0]` = 458752 (7.0), all others 0, inhbt 0, four starts. Neuron 0 potentials are 458752, 888832 and 1292032 after timesteps 1–3, with no spike. Timestep 4 shows `o_spike = 1` at idx 0, and v = 0 afterwards.
- **Refractory:** continue the stimulus above. Timesteps 5–6 show no spike and v = 0. The next spike is on timestep 10.
- **Inhibition and exemption:** inhbt 655360, neuron 3 spiked in the previous timestep. Neuron 3 is not decremented. Each other non-refractory neuron with v = 0 and cur = 0 goes to -655360.
- **Saturation:** inhbt 655360, cur 0, repeated for 10 timesteps. v clamps at exactly -1310720 and never wraps.
- **Handshake:** `i_start` pulses at cycles 5 and 10 during a scan are ignored. Exactly 18 beats are produced, idx 0..17, followed by one `o_done`.
- **Abort:** `i_clr_state` at beat idx 7. `o_valid` is 0 from the next cycle, there is no `o_done`, and all state is 0. A new start then yields the full 18 beats. `reset_n` pulsed mid-scan gives the same outcome.
